// File: rtl/mem_array_ctrl.sv
// WIDTH x DEPTH register-array memory behind an IDLE/ACCESS/DONE request controller.
// Define PARITY_EN to store and check an even-parity bit per word.
module mem_array_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic             op,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             ready,
  output logic             valid,
  output logic             rw,
  output logic [WIDTH-1:0] rdata,
  output logic             addr_err,
  output logic             parity_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [1:0]       state;
  logic             req_op;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;
  logic             perr_q;
  logic             perr_d;
  logic             in_range;
  logic             do_write;

  logic [WIDTH-1:0] mem [DEPTH];

  assign in_range = {1'b0, req_addr} < DEPTH_W;
  // reset in ACCESS must abort the write
  assign do_write = (state == ACCESS) && req_op
                  && in_range && !reset;

  always_ff @(posedge clk) begin
    if (do_write)
      mem[req_addr] <= req_wdata;
  end

`ifdef PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge clk) begin
    if (do_write)
      par[req_addr] <= ^req_wdata;
  end

  assign perr_d = in_range && !req_op
                && ((^mem[req_addr]) != par[req_addr]);
`else
  assign perr_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_op  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (select) begin
            req_op    <= op;
            req_addr  <= addr;
            req_wdata <= wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          err_q  <= !in_range;
          perr_q <= perr_d;
          if (!req_op)
            rdata_q <= in_range ? mem[req_addr] : '0;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready      = (state == IDLE);
  assign valid      = (state == DONE);
  assign rw         = valid && req_op;
  assign rdata      = rdata_q;
  assign addr_err   = valid && err_q;
  assign parity_err = valid && perr_q;

endmodule

// File: doc/mem_array_ctrl.md
Name: mem_array_ctrl

Overview:
Parametrised WIDTH x DEPTH word memory with an integrated request/acknowledge controller FSM. It is the successor to the fixed 8-bit memory word and its two-state-bit controller. It adds configurable width and depth, addressing, an explicit ready/valid handshake, out-of-range detection and optional per-word parity. It sits between a bus master and local storage and serves one transaction at a time.

Parameters:
WIDTH, 8, data bits per word (>=1)
DEPTH, 16, number of words (>=2, need not be a power of two)
AW, derived, address width = $clog2(DEPTH); local, not overridable

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
select  input  1  request strobe; sampled only when ready=1
op  input  1  transaction type: 1 = write, 0 = read
addr  input  AW  word address
wdata  input  WIDTH  write data
ready  output  1  controller idle, request may be presented
valid  output  1  one-cycle completion pulse
rw  output  1  type of the completed transaction (1 = write), meaningful while valid=1
rdata  output  WIDTH  read data; held until the next completed read
addr_err  output  1  completed transaction addressed a word >= DEPTH; qualified by valid
parity_err  output  1  parity mismatch on the completed read; qualified by valid

Behaviour:
- Reset: on a clk edge with reset=1, the following take effect at that edge:
  - state=IDLE, ready=1, valid=0, rw=0, rdata=0, addr_err=0, parity_err=0.
  - Storage contents are NOT cleared.
  - reset has priority over every other event.
- States: IDLE, ACCESS, DONE.
- IDLE (ready=1): if select=1 at edge N, capture op/addr/wdata into request registers and go to ACCESS; otherwise stay.
- ACCESS (ready=0), at edge N+1:
  - Write, in range: mem[addr] <= wdata.
  - Read, in range: rdata <= mem[addr].
  - Out of range (addr >= DEPTH): no storage change; a read loads rdata <= 0; the error flag is registered.
  - Go to DONE.
- DONE (ready=0), cycle N+2: valid=1, rw=captured op, addr_err per the captured request. Next edge goes to IDLE.
- Timing: latency accept-edge to valid = 2 cycles. Minimum spacing between accepts = 3 cycles.
- select/op/addr/wdata are ignored while ready=0; they are not queued.
- valid, addr_err and parity_err are 0 outside DONE. rdata is unchanged by writes.
- Reset during ACCESS: the write is suppressed (memory unchanged) and rdata is cleared. No valid pulse is issued for the aborted transaction.
- Reset during DONE: valid drops at that edge.
- Address wrap: none. addr is taken as-is, and values >= DEPTH follow the error path.
- Storage is a flat register array. Reads are registered, never combinational.

Optional Feature:
PARITY_EN
- Defined:
  - Each word stores one extra even-parity bit = ^wdata, computed on write.
  - A read recomputes parity over the stored data and compares it with the stored bit. parity_err=1 in DONE on mismatch.
  - rdata still returns the stored data.
  - Out-of-range reads give parity_err=0.
- Not defined: no parity storage; parity_err is tied 0. The port list is identical in both cases.

Test Plan:
1. WIDTH=8, DEPTH=16: write 0xA5 to addr 3, then read addr 3 -> write completes with valid=1, rw=1 two cycles after accept; read gives valid=1, rw=0, rdata=0xA5, addr_err=0.
2. Write 0x11 to addr 0 and 0xEE to addr 15, then read both -> rdata=0x11, then 0xEE. ready=0 for exactly 2 cycles after each accept.
3. DEPTH=12: write 0x55 to addr 13, then read addr 13 and addr 11 (preloaded 0x3C) -> both addr-13 transactions give addr_err=1 with valid, and the read returns rdata=0. Reading addr 11 gives 0x3C, showing no alias corruption.
4. Write 0x0F to addr 5. Accept a write of 0xF0 to addr 5, then assert reset for one cycle during ACCESS. Then read addr 5 -> no valid for the aborted write; outputs are at reset values; the read returns 0x0F.
5. Hold select=1 continuously with op=1, addr stepping 1,2,3 each cycle -> only the addresses sampled while ready=1 are written, with exactly one valid pulse per accept and accepts 3 cycles apart.
6. PARITY_EN defined: write 0x81 to addr 7, force one stored data bit of word 7 via hierarchical force, then read addr 7 -> valid=1, parity_err=1. Reading an unforced word gives parity_err=0.
